// File: rtl/sim_axi_mem_bank.sv
// Simulation memory with an AXI-style slave port: independent read and write
// burst engines sharing one word array, byte strobes, read latency and SLVERR.
module sim_axi_mem_bank #(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 64,
    parameter int ID_BITS    = 8,
    parameter int LEN_BITS   = 8,
    parameter int MEM_WORDS  = 4096,
    parameter int RD_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_axi_aw_ready,
    input  logic                   io_axi_aw_valid,
    input  logic [ADDR_BITS-1:0]   io_axi_aw_bits_addr,
    input  logic [ID_BITS-1:0]     io_axi_aw_bits_id,
    input  logic [LEN_BITS-1:0]    io_axi_aw_bits_len,
    output logic                   io_axi_w_ready,
    input  logic                   io_axi_w_valid,
    input  logic [DATA_BITS-1:0]   io_axi_w_bits_data,
    input  logic [DATA_BITS/8-1:0] io_axi_w_bits_strb,
    input  logic                   io_axi_w_bits_last,
    input  logic                   io_axi_b_ready,
    output logic                   io_axi_b_valid,
    output logic [ID_BITS-1:0]     io_axi_b_bits_id,
    output logic [1:0]             io_axi_b_bits_resp,
    output logic                   io_axi_ar_ready,
    input  logic                   io_axi_ar_valid,
    input  logic [ADDR_BITS-1:0]   io_axi_ar_bits_addr,
    input  logic [ID_BITS-1:0]     io_axi_ar_bits_id,
    input  logic [LEN_BITS-1:0]    io_axi_ar_bits_len,
    input  logic                   io_axi_r_ready,
    output logic                   io_axi_r_valid,
    output logic [DATA_BITS-1:0]   io_axi_r_bits_data,
    output logic                   io_axi_r_bits_last,
    output logic [ID_BITS-1:0]     io_axi_r_bits_id
);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int OFF_BITS  = $clog2(STRB_BITS);
    localparam int IDX_BITS  = $clog2(MEM_WORDS);
    localparam int WAIT_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WAIT_BITS-1:0] WAIT_INIT = (RD_LATENCY > 0) ? WAIT_BITS'(RD_LATENCY - 1) : '0;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

    logic [DATA_BITS-1:0] mem_q [MEM_WORDS];

    wr_state_e            wr_state_q, wr_state_d;
    logic [IDX_BITS-1:0]  wr_idx_q, wr_idx_d;
    logic [ID_BITS-1:0]   wr_id_q, wr_id_d;
    logic [LEN_BITS-1:0]  wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic                 wr_err_q, wr_err_d;

    rd_state_e            rd_state_q, rd_state_d;
    logic [IDX_BITS-1:0]  rd_idx_q, rd_idx_d;
    logic [ID_BITS-1:0]   rd_id_q, rd_id_d;
    logic [LEN_BITS-1:0]  rd_len_q, rd_len_d, rd_beat_q, rd_beat_d;
    logic [WAIT_BITS-1:0] rd_wait_q, rd_wait_d;
    logic [DATA_BITS-1:0] r_data_q, r_data_d;
    logic                 r_last_q, r_last_d;
    logic                 rd_load;

    logic aw_fire, w_fire, b_fire, ar_fire;
    logic unused_addr_bits;

    assign aw_fire = io_axi_aw_valid && io_axi_aw_ready;
    assign w_fire  = io_axi_w_valid && io_axi_w_ready;
    assign b_fire  = io_axi_b_valid && io_axi_b_ready;
    assign ar_fire = io_axi_ar_valid && io_axi_ar_ready;
    assign unused_addr_bits = ^{io_axi_aw_bits_addr, io_axi_ar_bits_addr};

    assign io_axi_aw_ready    = (wr_state_q == W_IDLE);
    assign io_axi_w_ready     = (wr_state_q == W_DATA);
    assign io_axi_b_valid     = (wr_state_q == W_RESP);
    assign io_axi_b_bits_id   = wr_id_q;
    assign io_axi_b_bits_resp = (io_axi_b_valid && wr_err_q) ? 2'd2 : 2'd0;

    assign io_axi_ar_ready    = (rd_state_q == R_IDLE);
    assign io_axi_r_valid     = (rd_state_q == R_DATA);
    assign io_axi_r_bits_data = r_data_q;
    assign io_axi_r_bits_last = io_axi_r_valid && r_last_q;
    assign io_axi_r_bits_id   = rd_id_q;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_id_d    = wr_id_q;
        wr_len_d   = wr_len_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        case (wr_state_q)
            W_IDLE: if (aw_fire) begin
                wr_idx_d   = io_axi_aw_bits_addr[OFF_BITS +: IDX_BITS];
                wr_id_d    = io_axi_aw_bits_id;
                wr_len_d   = io_axi_aw_bits_len;
                wr_cnt_d   = '0;
                wr_err_d   = 1'b0;
                wr_state_d = W_DATA;
            end
            W_DATA: if (w_fire) begin
                wr_idx_d = wr_idx_q + 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                // Short and overlong bursts both end in SLVERR; the flag is sticky.
                if (io_axi_w_bits_last) begin
                    wr_state_d = W_RESP;
                    if (wr_cnt_q != wr_len_q) wr_err_d = 1'b1;
                end else if (wr_cnt_q == wr_len_q) begin
                    wr_err_d = 1'b1;
                end
            end
            W_RESP: if (b_fire) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_id_d    = rd_id_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        rd_wait_d  = rd_wait_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: if (ar_fire) begin
                rd_idx_d  = io_axi_ar_bits_addr[OFF_BITS +: IDX_BITS];
                rd_id_d   = io_axi_ar_bits_id;
                rd_len_d  = io_axi_ar_bits_len;
                rd_beat_d = '0;
                if (RD_LATENCY == 0) begin
                    rd_state_d = R_DATA;
                    rd_load    = 1'b1;
                end else begin
                    rd_state_d = R_WAIT;
                    rd_wait_d  = WAIT_INIT;
                end
            end
            R_WAIT: if (rd_wait_q == '0) begin
                rd_state_d = R_DATA;
                rd_load    = 1'b1;
            end else begin
                rd_wait_d = rd_wait_q - 1'b1;
            end
            R_DATA: if (io_axi_r_ready) begin
                if (r_last_q) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_idx_d  = rd_idx_q + 1'b1;
                    rd_beat_d = rd_beat_q + 1'b1;
                    rd_load   = 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // The beat is snapshotted when presented, so a stalled beat ignores later writes.
    always_comb begin
        r_data_d = r_data_q;
        r_last_d = r_last_q;
        if (rd_load) begin
            r_data_d = mem_q[rd_idx_d];
            r_last_d = (rd_beat_d == rd_len_d);
        end
    end

    always_ff @(posedge clock) begin
        if (w_fire && !reset) begin
            for (int b = 0; b < STRB_BITS; b++) begin
                if (io_axi_w_bits_strb[b]) mem_q[wr_idx_q][b*8 +: 8] <= io_axi_w_bits_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_id_q    <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_wait_q  <= '0;
            r_data_q   <= '0;
            r_last_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_id_q    <= wr_id_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
            rd_wait_q  <= rd_wait_d;
            r_data_q   <= r_data_d;
            r_last_q   <= r_last_d;
        end
    end
endmodule

// File: tb/tb_sim_axi_mem_bank.sv
// Bench for sim_axi_mem_bank: burst table, latency, stall, mismatch, wrap and reset cases
// against a word-array model and R/B expectation queues.
module tb_sim_axi_mem_bank;
    localparam int MEM_WORDS = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        aw_ready, aw_valid;
    logic [31:0] aw_addr;
    logic [7:0]  aw_id, aw_len;
    logic        w_ready, w_valid, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_ready, b_valid;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_ready, ar_valid;
    logic [31:0] ar_addr;
    logic [7:0]  ar_id, ar_len;
    logic        r_ready, r_valid, r_last;
    logic [63:0] r_data;
    logic [7:0]  r_id;

    logic        l0_ar_valid, l0_ar_ready, l0_r_valid, l0_r_last;
    logic [7:0]  l0_r_id;
    logic        l0_unused_aw_ready, l0_unused_w_ready, l0_unused_b_valid;
    logic [7:0]  l0_unused_b_id;
    logic [1:0]  l0_unused_b_resp;
    logic [63:0] l0_unused_r_data;

    sim_axi_mem_bank dut (
        .clock(clock), .reset(reset),
        .io_axi_aw_ready(aw_ready), .io_axi_aw_valid(aw_valid), .io_axi_aw_bits_addr(aw_addr),
        .io_axi_aw_bits_id(aw_id), .io_axi_aw_bits_len(aw_len),
        .io_axi_w_ready(w_ready), .io_axi_w_valid(w_valid), .io_axi_w_bits_data(w_data),
        .io_axi_w_bits_strb(w_strb), .io_axi_w_bits_last(w_last),
        .io_axi_b_ready(b_ready), .io_axi_b_valid(b_valid), .io_axi_b_bits_id(b_id),
        .io_axi_b_bits_resp(b_resp),
        .io_axi_ar_ready(ar_ready), .io_axi_ar_valid(ar_valid), .io_axi_ar_bits_addr(ar_addr),
        .io_axi_ar_bits_id(ar_id), .io_axi_ar_bits_len(ar_len),
        .io_axi_r_ready(r_ready), .io_axi_r_valid(r_valid), .io_axi_r_bits_data(r_data),
        .io_axi_r_bits_last(r_last), .io_axi_r_bits_id(r_id)
    );

    sim_axi_mem_bank #(.RD_LATENCY(0)) dut_l0 (
        .clock(clock), .reset(reset),
        .io_axi_aw_ready(l0_unused_aw_ready), .io_axi_aw_valid(1'b0), .io_axi_aw_bits_addr(32'h0),
        .io_axi_aw_bits_id(8'h0), .io_axi_aw_bits_len(8'h0),
        .io_axi_w_ready(l0_unused_w_ready), .io_axi_w_valid(1'b0), .io_axi_w_bits_data(64'h0),
        .io_axi_w_bits_strb(8'h0), .io_axi_w_bits_last(1'b0),
        .io_axi_b_ready(1'b1), .io_axi_b_valid(l0_unused_b_valid), .io_axi_b_bits_id(l0_unused_b_id),
        .io_axi_b_bits_resp(l0_unused_b_resp),
        .io_axi_ar_ready(l0_ar_ready), .io_axi_ar_valid(l0_ar_valid), .io_axi_ar_bits_addr(ar_addr),
        .io_axi_ar_bits_id(ar_id), .io_axi_ar_bits_len(ar_len),
        .io_axi_r_ready(1'b1), .io_axi_r_valid(l0_r_valid), .io_axi_r_bits_data(l0_unused_r_data),
        .io_axi_r_bits_last(l0_r_last), .io_axi_r_bits_id(l0_r_id)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got no response expected one", name);
    endtask

    // Scoreboard: R beats packed as {last, id, data}; B responses as {id, resp}.
    logic [72:0] exp_q[$];
    logic [9:0]  b_exp_q[$];
    logic [63:0] model_mem[int];

    always @(negedge clock) begin
        if (!reset && r_valid && r_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_r_beat");
            else check("r_beat", {r_last, r_id, r_data}, exp_q.pop_front());
        end
        if (!reset && b_valid && b_ready) begin
            if (b_exp_q.size() == 0) fail_now("unexpected_b");
            else check("b_resp", {b_id, b_resp}, b_exp_q.pop_front());
        end
    end

    function automatic int widx(input logic [31:0] a, input int k);
        return int'(((a >> 3) + 32'(k)) % 32'(MEM_WORDS));
    endfunction

    task automatic aw_send(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len);
        int n = 0;
        aw_valid = 1'b1; aw_addr = a; aw_id = id; aw_len = len;
        do begin @(negedge clock); n++; end while (!aw_ready && n < 50);
        if (!aw_ready) fail_now("aw_handshake");
        @(posedge clock); #1 aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len);
        int n = 0;
        ar_valid = 1'b1; ar_addr = a; ar_id = id; ar_len = len;
        do begin @(negedge clock); n++; end while (!ar_ready && n < 50);
        if (!ar_ready) fail_now("ar_handshake");
        @(posedge clock); #1 ar_valid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic l, input int idx);
        int n = 0;
        logic [63:0] cur;
        w_valid = 1'b1; w_data = d; w_strb = s; w_last = l;
        do begin @(negedge clock); n++; end while (!w_ready && n < 50);
        if (!w_ready) fail_now("w_handshake");
        else begin
            cur = model_mem.exists(idx) ? model_mem[idx] : 64'bx;
            for (int b = 0; b < 8; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
            model_mem[idx] = cur;
        end
        @(posedge clock); #1 w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len,
                               input int nb, input logic [63:0] base, input logic [63:0] step,
                               input logic [7:0] s, input logic [1:0] resp);
        int n = 0;
        b_exp_q.push_back({id, resp});
        aw_send(a, id, len);
        for (int k = 0; k < nb; k++) w_send(base + 64'(k) * step, s, k == nb - 1, widx(a, k));
        while (b_exp_q.size() != 0 && n < 50) begin @(posedge clock); #1; n++; end
        if (b_exp_q.size() != 0) begin fail_now("b_timeout"); b_exp_q.delete(); end
    endtask

    task automatic rd_push(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len);
        for (int k = 0; k <= int'(len); k++) exp_q.push_back({(k == int'(len)), id, model_mem[widx(a, k)]});
    endtask

    task automatic rd_drain(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock); #1 r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        r_ready = 1'b1;
        if (exp_q.size() != 0) begin fail_now("r_timeout"); exp_q.delete(); end
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len, input bit rnd);
        rd_push(a, id, len);
        ar_send(a, id, len);
        rd_drain(rnd);
    endtask

    typedef struct {
        logic [31:0] addr;  logic [7:0] wid;  logic [7:0] len;  int nbeats;
        logic [63:0] base;  logic [63:0] step; logic [7:0] strb; logic [1:0] resp;
        logic [31:0] raddr; logic [7:0] rid;  bit rnd;
    } vec_t;
    vec_t vecs[8];

    initial begin
        logic [63:0] stall_exp;
        logic [31:0] ra;
        logic [7:0]  rl;
        int n;

        vecs[0] = '{32'h100,      8'h05, 8'd3, 4, 64'h11,                   64'h11,   8'hFF, 2'd0, 32'h100,  8'h09, 1'b0};
        vecs[1] = '{32'h200,      8'h01, 8'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF,  64'h0,    8'hFF, 2'd0, 32'h200,  8'h02, 1'b0};
        vecs[2] = '{32'h200,      8'h02, 8'd0, 1, 64'h0,                    64'h0,    8'h0F, 2'd0, 32'h200,  8'h03, 1'b0};
        vecs[3] = '{32'h300,      8'h21, 8'd3, 2, 64'h0123_4567_89AB_CDEF,  64'h1111, 8'hFF, 2'd2, 32'h300,  8'h44, 1'b1};
        vecs[4] = '{32'h7FF8,     8'h03, 8'd1, 2, 64'hCAFE_0000_0000_0000,  64'h1,    8'hFF, 2'd0, 32'h7FF8, 8'h55, 1'b1};
        vecs[5] = '{32'h400,      8'h07, 8'd1, 3, 64'h5A5A_5A5A_0000_0000,  64'h100,  8'hFF, 2'd2, 32'h400,  8'h66, 1'b1};
        vecs[6] = '{32'h1005,     8'hFF, 8'd2, 3, 64'h1, 64'h0101_0101_0101_0101,     8'hFF, 2'd0, 32'h1000, 8'hEE, 1'b1};
        vecs[7] = '{32'h0001_0108, 8'h80, 8'd1, 2, 64'hBEEF,                64'h10000, 8'hFF, 2'd0, 32'h108, 8'h01, 1'b0};

        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 1;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; r_ready = 1; l0_ar_valid = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst aw_ready", aw_ready, 1'b1);
        check("rst ar_ready", ar_ready, 1'b1);
        check("rst w_ready", w_ready, 1'b0);
        check("rst b_valid", b_valid, 1'b0);
        check("rst r_valid", r_valid, 1'b0);
        check("rst r_last", r_last, 1'b0);
        check("rst b_resp", b_resp, 2'd0);
        check("rst b_id", b_id, 8'd0);
        check("rst r_id", r_id, 8'd0);
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            write_burst(vecs[i].addr, vecs[i].wid, vecs[i].len, vecs[i].nbeats,
                        vecs[i].base, vecs[i].step, vecs[i].strb, vecs[i].resp);
            rd_burst(vecs[i].raddr, vecs[i].rid, 8'(vecs[i].nbeats - 1), vecs[i].rnd);
        end

        // Partial-strobe merge result, stated independently of the model.
        exp_q.push_back({1'b1, 8'hAA, 64'hFFFF_FFFF_0000_0000});
        ar_send(32'h200, 8'hAA, 8'd0);
        rd_drain(1'b0);

        // Read latency: RD_LATENCY=2 instance and RD_LATENCY=0 instance, same AR edge.
        rd_push(32'h100, 8'h07, 8'd0);
        ar_addr = 32'h100; ar_id = 8'h07; ar_len = 8'd0; ar_valid = 1'b1; l0_ar_valid = 1'b1;
        @(negedge clock);
        check("lat ar_ready", ar_ready, 1'b1);
        check("lat0 ar_ready", l0_ar_ready, 1'b1);
        @(posedge clock); #1 ar_valid = 1'b0; l0_ar_valid = 1'b0;
        @(negedge clock);
        check("lat2 c+1 r_valid", r_valid, 1'b0);
        check("lat0 c+1 r_valid", l0_r_valid, 1'b1);
        check("lat0 c+1 r_last", l0_r_last, 1'b1);
        check("lat0 c+1 r_id", l0_r_id, 8'h07);
        @(negedge clock);
        check("lat2 c+2 r_valid", r_valid, 1'b0);
        check("lat0 c+2 r_valid", l0_r_valid, 1'b0);
        @(negedge clock);
        check("lat2 c+3 r_valid", r_valid, 1'b1);
        rd_drain(1'b0);

        // Stall beat 1 of a burst while the same word is overwritten.
        write_burst(32'h600, 8'h01, 8'd3, 4, 64'hA0A0_0000_0000_0001, 64'h1, 8'hFF, 2'd0);
        rd_push(32'h600, 8'h33, 8'd3);
        ar_send(32'h600, 8'h33, 8'd3);
        n = 0;
        do begin @(negedge clock); n++; end while (!r_valid && n < 20);
        if (!r_valid) fail_now("stall first beat");
        @(posedge clock); #1 r_ready = 1'b0;
        stall_exp = model_mem[widx(32'h600, 1)];
        fork
            write_burst(32'h608, 8'h02, 8'd0, 1, 64'hDEAD_BEEF_0BAD_F00D, 64'h0, 8'hFF, 2'd0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                check("stall r_valid", r_valid, 1'b1);
                check("stall r_data", r_data, stall_exp);
                check("stall r_last", r_last, 1'b0);
                check("stall r_id", r_id, 8'h33);
            end
        join
        rd_drain(1'b0);
        rd_burst(32'h608, 8'h34, 8'd0, 1'b0);

        // Short random traffic in a separate region.
        for (int t = 0; t < 6; t++) begin
            ra = 32'h8000 + 32'(8 * $urandom_range(0, 63));
            rl = 8'($urandom_range(0, 7));
            write_burst(ra, 8'(t), rl, int'(rl) + 1, {$urandom, $urandom}, 64'h1, 8'hFF, 2'd0);
            rd_burst(ra, 8'(t + 16), rl, 1'b1);
        end

        // Reset in the middle of both a write burst and a stalled read burst.
        r_ready = 1'b0;
        aw_send(32'h500, 8'h04, 8'd3);
        w_send(64'h7777_0000_1234_5678, 8'hFF, 1'b0, widx(32'h500, 0));
        ar_send(32'h100, 8'h06, 8'd3);
        repeat (3) @(negedge clock);
        check("pre-reset r_valid", r_valid, 1'b1);
        check("pre-reset aw_ready", aw_ready, 1'b0);
        check("pre-reset ar_ready", ar_ready, 1'b0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        exp_q.delete();
        b_exp_q.delete();
        r_ready = 1'b1;
        @(negedge clock);
        check("mid-reset r_valid", r_valid, 1'b0);
        check("mid-reset b_valid", b_valid, 1'b0);
        check("mid-reset ar_ready", ar_ready, 1'b1);
        check("mid-reset aw_ready", aw_ready, 1'b1);
        check("mid-reset w_ready", w_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post-reset quiet", {b_valid, r_valid}, 2'b00);
        end
        @(posedge clock); #1;
        rd_burst(32'h100, 8'h0C, 8'd3, 1'b0);
        rd_burst(32'h500, 8'h12, 8'd0, 1'b0);

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test expected one");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sim_axi_mem_bank.md
Name: sim_axi_mem_bank

Overview:
- Parametrised simulation memory model presenting an AXI-style slave port.
- Next generation of the simulation memory behind the sim shell: configurable data, address, ID and length widths; write strobes; write IDs; R-channel backpressure; programmable read latency; SLVERR on burst-length mismatch.
- Independent read and write engines share one internal word array. Sits between the accelerator's memory master and the testbench.

Parameters:
- ADDR_BITS, 32, byte address width
- DATA_BITS, 64, beat width; power of two, >= 8
- ID_BITS, 8, AR/AW/R/B ID width
- LEN_BITS, 8, burst length field width (beats = len+1)
- MEM_WORDS, 4096, array depth in DATA_BITS words; power of two
- RD_LATENCY, 2, cycles from AR handshake to first R beat valid; 0 allowed

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_axi_aw_ready  out  1  write address ready
- io_axi_aw_valid  in  1  write address valid
- io_axi_aw_bits_addr  in  ADDR_BITS  burst start byte address
- io_axi_aw_bits_id  in  ID_BITS  write ID
- io_axi_aw_bits_len  in  LEN_BITS  beats-1
- io_axi_w_ready  out  1
- io_axi_w_valid  in  1
- io_axi_w_bits_data  in  DATA_BITS
- io_axi_w_bits_strb  in  DATA_BITS/8  byte enables
- io_axi_w_bits_last  in  1
- io_axi_b_ready  in  1
- io_axi_b_valid  out  1
- io_axi_b_bits_id  out  ID_BITS
- io_axi_b_bits_resp  out  2  0=OKAY, 2=SLVERR
- io_axi_ar_ready  out  1
- io_axi_ar_valid  in  1
- io_axi_ar_bits_addr  in  ADDR_BITS
- io_axi_ar_bits_id  in  ID_BITS
- io_axi_ar_bits_len  in  LEN_BITS
- io_axi_r_ready  in  1  R backpressure
- io_axi_r_valid  out  1
- io_axi_r_bits_data  out  DATA_BITS
- io_axi_r_bits_last  out  1
- io_axi_r_bits_id  out  ID_BITS

Behaviour:
- One clock; reset is synchronous, active-high, sampled on rising clock.
- Reset values: aw_ready=1, ar_ready=1; w_ready, b_valid, r_valid, r_last = 0; b_resp, b_id, r_id = 0. Both FSMs go to IDLE. Array contents are not cleared.
- Reset mid-burst: the burst is abandoned and no B or R is produced.
- Word index = (addr >> log2(DATA_BITS/8)) mod MEM_WORDS. Low offset bits are ignored. INCR bursts only. Index wraps from MEM_WORDS-1 to 0.
- Write FSM:
  - W_IDLE (aw_ready=1): on aw handshake, latch index, id and len; beat counter = 0; go to W_DATA.
  - W_DATA (w_ready=1, aw_ready=0): on each w handshake, write the bytes whose strb bit is 1 at the edge, then index+1 and counter+1.
  - The beat carrying w_last ends the burst; go to W_RESP.
  - Mismatch flag is set if last arrives with counter != len, or if counter passes len without last. Extra beats keep writing at incrementing addresses.
  - W_RESP: b_valid=1, b_id = latched id, b_resp = mismatch ? 2 : 0. Held stable until b_ready; on handshake go to W_IDLE. Next AW is accepted no earlier than the following cycle.
- Read FSM:
  - R_IDLE (ar_ready=1): on ar handshake, latch index, id and len. If RD_LATENCY>0, load the wait counter and go to R_WAIT; otherwise go directly to R_DATA.
  - R_WAIT: the wait counter decrements each cycle. r_valid rises exactly RD_LATENCY+1 cycles after the AR handshake edge. For RD_LATENCY=0, r_valid is high the cycle after the handshake.
  - R_DATA: r_valid=1, r_data = array[index], r_id = latched id, r_last = (beat == len).
  - While r_ready=0, data, last and id are held stable. Data is captured into an output register when the beat is presented, so a concurrent write does not alter a stalled beat.
  - On handshake: if last, go to R_IDLE; else index+1 and beat+1, and the next beat is valid in the following cycle (1 beat/cycle at full throughput).
- Read/write concurrency: both engines run in parallel. A write committed at edge t is visible to any R beat registered at edge t+1 or later.
- Only one outstanding burst per direction; ar_ready and aw_ready stay 0 until the current burst completes.

Test Plan:
- AW addr 0x100, len 3, id 5, four beats 0x11..0x44 with strb 0xFF, last on beat 3 -> b_valid with b_id=5, resp=0. Then AR addr 0x100, len 3, id 9 -> 4 beats 0x11,0x22,0x33,0x44, r_last only on the 4th, r_id=9.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x200, then write 0x0 with strb 0x0F -> readback 0xFFFF_FFFF_0000_0000.
- RD_LATENCY=2 and RD_LATENCY=0 builds, AR accepted at cycle c -> first r_valid at c+3 and c+1 respectively.
- r_ready held low 5 cycles mid-burst while a write to the stalled beat's address occurs -> r_data, r_last and r_id unchanged throughout; no beat skipped or duplicated.
- AW len 3 but w_last on beat 1 -> b_resp=2. AW addr = last word (MEM_WORDS-1)*8, len 1 -> second beat lands at word 0.
- Reset asserted mid read burst and mid write burst -> next cycle r_valid=0, b_valid=0, ar_ready=1, aw_ready=1; previously written memory data still readable.
